// File: rtl/filter_pkg.sv
// Shared constants and state type for the filter tap loader / row streamer.
package filter_pkg;
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DEPTH_F    = 5;
  localparam int DEF_WIDTH      = 8;
  localparam int DEF_PACK_WIDTH = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    SEND = 2'd2
  } state_t;
endpackage

// File: rtl/filter_mem.sv
// Tap storage: single write port, one packed row read out per lane (tap column).
module filter_mem
  import filter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH_F    = DEF_DEPTH_F,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PACK_WIDTH = DEF_PACK_WIDTH,
  parameter int RW         = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [RW-1:0]         rd_row,
  output logic [PACK_WIDTH-1:0] rd_data
);
  localparam int NTAPS = DEPTH_F * DEPTH_F;
  localparam int IW    = $clog2(NTAPS + DEPTH_F);

  logic [NTAPS-1:0][WIDTH-1:0]   taps;
  logic [DEPTH_F-1:0][WIDTH-1:0] row;
  logic [IW-1:0]                 base;

  // Out-of-range addresses are silently dropped; the handshake is still consumed upstream.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)                                    taps <= '0;
    else if (wr_en && (int'(wr_addr) < NTAPS))     taps[wr_addr] <= wr_data;

  assign base = IW'(rd_row) * IW'(DEPTH_F);

  for (genvar k = 0; k < DEPTH_F; k++) begin : g_lane
    logic [IW-1:0] idx;
    assign idx    = base + IW'(k);
    assign row[k] = (int'(idx) < NTAPS) ? taps[idx] : '0;
  end

  assign rd_data = PACK_WIDTH'(row);
endmodule

// File: rtl/filter.sv
// Filter loader: address/value tap writes, then streams DEPTH_F packed rows out.
module filter
  import filter_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DEPTH_F    = DEF_DEPTH_F,
  parameter int WIDTH      = DEF_WIDTH,
  parameter int PACK_WIDTH = DEF_PACK_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start_valid,
  output logic                  load_start_ready,
  input  logic                  filter_addr_valid,
  input  logic [ADDR_WIDTH-1:0] filter_addr_data,
  output logic                  filter_addr_ready,
  input  logic                  filter_data_valid,
  input  logic [WIDTH-1:0]      filter_data_data,
  output logic                  filter_data_ready,
  input  logic                  load_done_valid,
  output logic                  load_done_ready,
  output logic                  filter_out_valid,
  output logic [PACK_WIDTH-1:0] filter_out_data,
  input  logic                  filter_out_ready
);
  localparam int RW = (DEPTH_F > 1) ? $clog2(DEPTH_F) : 1;

  state_t                state, state_nxt;
  logic                  held;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [RW-1:0]         row_cnt, rd_row;
  logic [PACK_WIDTH-1:0] rd_data;
  logic                  addr_xfer, data_xfer, done_xfer, out_xfer, last_row;

  assign addr_xfer = filter_addr_valid & filter_addr_ready;
  assign data_xfer = filter_data_valid & filter_data_ready;
  assign done_xfer = load_done_valid   & load_done_ready;
  assign out_xfer  = filter_out_valid  & filter_out_ready;
  assign last_row  = (row_cnt == RW'(DEPTH_F - 1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // Readies are gated by rst_n so every handshake is dead while reset is held.
  always_comb begin
    state_nxt         = state;
    load_start_ready  = 1'b0;
    filter_addr_ready = 1'b0;
    filter_data_ready = 1'b0;
    load_done_ready   = 1'b0;
    filter_out_valid  = 1'b0;
    if (rst_n) begin
      case (state)
        IDLE: begin
          load_start_ready = 1'b1;
          if (load_start_valid) state_nxt = LOAD;
        end
        LOAD: begin
          filter_addr_ready = !held;
          filter_data_ready = held;
          load_done_ready   = !held;
          if (load_done_valid && !held) state_nxt = SEND;
        end
        SEND: begin
          filter_out_valid = 1'b1;
          if (filter_out_ready && last_row) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Prefetch the row that will be on the bus after the next transfer.
  assign rd_row = (state == SEND) ? row_cnt + RW'(1) : '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      held            <= 1'b0;
      addr_q          <= '0;
      row_cnt         <= '0;
      filter_out_data <= '0;
    end else begin
      if (addr_xfer) addr_q <= filter_addr_data;
      // An address arriving alongside load_done is dropped with the load.
      if (done_xfer)      held <= 1'b0;
      else if (addr_xfer) held <= 1'b1;
      else if (data_xfer) held <= 1'b0;
      if (done_xfer) begin
        row_cnt         <= '0;
        filter_out_data <= rd_data;
      end else if (out_xfer) begin
        row_cnt <= last_row ? '0 : row_cnt + RW'(1);
        if (!last_row) filter_out_data <= rd_data;
      end
    end

  filter_mem #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DEPTH_F   (DEPTH_F),
    .WIDTH     (WIDTH),
    .PACK_WIDTH(PACK_WIDTH),
    .RW        (RW)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .wr_en  (data_xfer),
    .wr_addr(addr_q),
    .wr_data(filter_data_data),
    .rd_row (rd_row),
    .rd_data(rd_data)
  );
endmodule

// File: tb/tb_filter.sv
// Directed bench for filter: scoreboard of expected rows checked on each output transfer.
module tb_filter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load_start_valid = 1'b0, load_start_ready;
  logic        filter_addr_valid = 1'b0, filter_addr_ready;
  logic [4:0]  filter_addr_data = '0;
  logic        filter_data_valid = 1'b0, filter_data_ready;
  logic [7:0]  filter_data_data = '0;
  logic        load_done_valid = 1'b0, load_done_ready;
  logic        filter_out_valid, filter_out_ready = 1'b0;
  logic [63:0] filter_out_data;

  int          n_assert = 0, n_fail = 0;
  logic [7:0]  m [25];
  logic [63:0] exp_q [$];
  logic [63:0] e;

  always #5 clk = ~clk;

  filter dut (
    .clk(clk), .rst_n(rst_n),
    .load_start_valid(load_start_valid), .load_start_ready(load_start_ready),
    .filter_addr_valid(filter_addr_valid), .filter_addr_data(filter_addr_data),
    .filter_addr_ready(filter_addr_ready),
    .filter_data_valid(filter_data_valid), .filter_data_data(filter_data_data),
    .filter_data_ready(filter_data_ready),
    .load_done_valid(load_done_valid), .load_done_ready(load_done_ready),
    .filter_out_valid(filter_out_valid), .filter_out_data(filter_out_data),
    .filter_out_ready(filter_out_ready)
  );

  // Output monitor: each transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && filter_out_valid && filter_out_ready) begin
      n_assert++;
      assert (exp_q.size() != 0) else begin
        n_fail++; $error("FAIL unexpected_row data=%h expected none", filter_out_data);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_assert++;
        assert (filter_out_data === e) else begin
          n_fail++; $error("FAIL row data=%h expected %h", filter_out_data, e);
        end
      end
    end
  end

  function automatic logic [63:0] pack_row(input int r);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < 5; k++) v[k*8 +: 8] = m[r*5 + k];
    return v;
  endfunction

  function automatic logic chan_rdy(input int ch);
    case (ch)
      0: return load_start_ready;
      1: return filter_addr_ready;
      2: return filter_data_ready;
      default: return load_done_ready;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++; $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // Waits (bounded) for ready with valid already up; returns just after the transfer edge.
  task automatic wait_rdy(input int ch, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!chan_rdy(ch) && n < 50) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, 64'(chan_rdy(ch)), 64'd1);
    @(posedge clk); #1;
  endtask

  task automatic send_start();
    load_start_valid = 1'b1; wait_rdy(0, "start"); load_start_valid = 1'b0;
  endtask

  task automatic send_tap(input logic [4:0] a, input logic [7:0] v);
    filter_addr_valid = 1'b1; filter_addr_data = a;
    wait_rdy(1, "addr"); filter_addr_valid = 1'b0;
    filter_data_valid = 1'b1; filter_data_data = v;
    wait_rdy(2, "data"); filter_data_valid = 1'b0;
    if (a < 25) m[a] = v;
  endtask

  task automatic send_done();
    for (int r = 0; r < 5; r++) exp_q.push_back(pack_row(r));
    load_done_valid = 1'b1; wait_rdy(3, "done"); load_done_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
    chk({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    @(negedge clk);
    chk({tag, "_valid_low"}, 64'(filter_out_valid), 64'd0);
    chk({tag, "_idle"}, 64'(load_start_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 25; i++) m[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_readies", {60'd0, load_start_ready, filter_addr_ready, filter_data_ready,
        load_done_ready}, 64'd0);
    chk("rst_out_valid", 64'(filter_out_valid), 64'd0);
    chk("rst_out_data", filter_out_data, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_readies", {60'd0, load_start_ready, filter_addr_ready, filter_data_ready,
        load_done_ready}, 64'h8);
    @(posedge clk); #1;

    // Full load of taps i+1, continuous ready.
    send_start();
    for (int i = 0; i < 25; i++) send_tap(5'(i), 8'(i + 1));
    filter_out_ready = 1'b1;
    send_done();
    @(negedge clk);
    chk("full_row0", filter_out_data, 64'h0000000504030201);
    drain("full");

    // Backpressure on row 2; taps unchanged from the full load.
    filter_out_ready = 1'b0;
    send_start();
    send_done();
    for (int r = 0; r < 5; r++) begin
      if (r == 2) begin
        repeat (3) begin
          @(negedge clk);
          chk("bp_hold_data", filter_out_data, 64'h0000000F0E0D0C0B);
          chk("bp_hold_valid", 64'(filter_out_valid), 64'd1);
          @(posedge clk); #1;
        end
      end
      filter_out_ready = 1'b1;
      @(posedge clk); #1;
      filter_out_ready = 1'b0;
    end
    drain("bp");

    // Data presented before address, then partial reload plus out-of-range tap.
    send_start();
    filter_data_valid = 1'b1; filter_data_data = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      chk("order_data_ready", 64'(filter_data_ready), 64'd0);
    end
    @(posedge clk); #1;
    filter_addr_valid = 1'b1; filter_addr_data = 5'd0;
    wait_rdy(1, "order_addr"); filter_addr_valid = 1'b0;
    wait_rdy(2, "order_data"); filter_data_valid = 1'b0;
    m[0] = 8'hAA;
    send_tap(5'd31, 8'hFF);
    filter_out_ready = 1'b1;
    send_done();
    @(negedge clk);
    chk("partial_row0", filter_out_data, 64'h00000005040302AA);
    drain("partial");

    // Reset in the middle of a load.
    send_start();
    for (int i = 0; i < 10; i++) send_tap(5'(i), 8'(8'h30 + i));
    rst_n = 1'b0;
    #2;
    chk("midrst_readies", {60'd0, load_start_ready, filter_addr_ready, filter_data_ready,
        load_done_ready}, 64'd0);
    chk("midrst_valid", 64'(filter_out_valid), 64'd0);
    chk("midrst_data", filter_out_data, 64'd0);
    for (int i = 0; i < 25; i++) m[i] = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1;
    load_done_valid = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("midrst_idle", 64'(load_start_ready), 64'd1);
      chk("midrst_done_blocked", 64'(load_done_ready), 64'd0);
      chk("midrst_no_out", 64'(filter_out_valid), 64'd0);
    end
    @(posedge clk); #1;
    load_done_valid = 1'b0;
    send_start();
    send_done();
    drain("cleared");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
